// File: rtl/mem_req_pkg.sv
// Shared types for the data-memory request queue: queued request record and issue FSM states.
package mem_req_pkg;

    localparam int unsigned DMEM_Q_DEPTH  = 4;
    localparam int unsigned MEM_REQ_TAG_W = 4;

    typedef struct packed {
        logic [31:0]              addr;
        logic [3:0]               rmask;
        logic [3:0]               wmask;
        logic [31:0]              wdata;
        logic [MEM_REQ_TAG_W-1:0] tag;
    } mem_req_t;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } dmem_q_state_e;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO of mem_req_t with a clear that preserves the current head entry.
module req_fifo
    import mem_req_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_Q_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  mem_req_t                   push_data,
    input  logic                       pop,
    input  logic                       clear_tail,
    output mem_req_t                   head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mem_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && !clear_tail && (count_q != CNT_W'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (clear_tail) begin
            // Keep only the head (it may already be issued); drop it too if popped now.
            if (count_q != '0) begin
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = do_pop ? CNT_W'(0) : CNT_W'(1);
            end
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/dmem_req_queue.sv
// In-order load/store queue issuing one op at a time on the single-outstanding dmem interface.
module dmem_req_queue
    import mem_req_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_Q_DEPTH,
    parameter int unsigned TAG_W = MEM_REQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [3:0]       req_rmask,
    input  logic [3:0]       req_wmask,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_is_load,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_rmask,
    output logic [3:0]       dmem_wmask,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_resp
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    dmem_q_state_e    state_q, state_d;
    logic             discard_q, discard_d;
    logic             inflight_is_load_q, inflight_is_load_d;
    logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
    logic [CNT_W-1:0] count;
    mem_req_t         head;
    mem_req_t         push_data;
    logic             push, pop;

    assign req_ready = (count != CNT_W'(DEPTH));
    // Zero-mask ops are accepted but never stored.
    assign push      = req_valid && req_ready && !flush && ((req_rmask != '0) || (req_wmask != '0));

    always_comb begin
        push_data       = '0;
        push_data.addr  = req_addr;
        push_data.rmask = req_rmask;
        push_data.wmask = req_wmask;
        push_data.wdata = req_wdata;
        push_data.tag   = MEM_REQ_TAG_W'(req_tag);
    end

    req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .clear_tail (flush),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        state_d            = state_q;
        discard_d          = discard_q;
        inflight_is_load_d = inflight_is_load_q;
        inflight_tag_d     = inflight_tag_q;
        pop                = 1'b0;
        dmem_addr          = '0;
        dmem_rmask         = '0;
        dmem_wmask         = '0;
        dmem_wdata         = '0;
        rsp_valid          = 1'b0;
        rsp_tag            = '0;
        rsp_rdata          = '0;
        rsp_is_load        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    dmem_addr          = head.addr;
                    dmem_rmask         = head.rmask;
                    dmem_wmask         = head.wmask;
                    dmem_wdata         = head.wdata;
                    inflight_is_load_d = (head.rmask != '0);
                    inflight_tag_d     = head.tag[TAG_W-1:0];
                    if (flush) begin
                        discard_d = 1'b1;
                    end
                    state_d = WAIT;
                end
            end
            WAIT: begin
                dmem_addr  = head.addr;
                dmem_wdata = head.wdata;
                if (dmem_resp) begin
                    pop       = 1'b1;
                    rsp_valid = !discard_q;
                    if (!discard_q) begin
                        rsp_tag     = inflight_tag_q;
                        rsp_is_load = inflight_is_load_q;
                        rsp_rdata   = inflight_is_load_q ? dmem_rdata : 32'h0;
                    end
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            discard_q          <= 1'b0;
            inflight_is_load_q <= 1'b0;
            inflight_tag_q     <= '0;
        end else begin
            state_q            <= state_d;
            discard_q          <= discard_d;
            inflight_is_load_q <= inflight_is_load_d;
            inflight_tag_q     <= inflight_tag_d;
        end
    end

endmodule

// File: tb/tb_dmem_req_queue.sv
// Directed bench for dmem_req_queue: load, fill, store, flush, push+pop, reset mid-wait.
module tb_dmem_req_queue;
    import mem_req_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_addr = '0;
    logic [3:0]       req_rmask = '0;
    logic [3:0]       req_wmask = '0;
    logic [31:0]      req_wdata = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_rdata;
    logic             rsp_is_load;
    logic [31:0]      dmem_addr;
    logic [3:0]       dmem_rmask;
    logic [3:0]       dmem_wmask;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata = '0;
    logic             dmem_resp = 1'b0;

    always #5 clk = ~clk;

    dmem_req_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_rmask   (req_rmask),
        .req_wmask   (req_wmask),
        .req_wdata   (req_wdata),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_tag     (rsp_tag),
        .rsp_rdata   (rsp_rdata),
        .rsp_is_load (rsp_is_load),
        .dmem_addr   (dmem_addr),
        .dmem_rmask  (dmem_rmask),
        .dmem_wmask  (dmem_wmask),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_resp   (dmem_resp)
    );

    int checks   = 0;
    int failures = 0;

    // Issue log entries: {addr, rmask, wmask}; response log entries: {is_load, tag, rdata}.
    logic [39:0] issues [$];
    logic [36:0] rsps [$];

    logic             got_valid;
    logic [TAG_W-1:0] got_tag;
    logic [31:0]      got_rdata;
    logic             got_load;
    logic             got_ready;

    always @(negedge clk) begin
        if (rst) begin
            if (dmem_rmask != 4'h0 || dmem_wmask != 4'h0) begin
                issues.push_back({dmem_addr, dmem_rmask, dmem_wmask});
            end
            if (rsp_valid) begin
                rsps.push_back({rsp_is_load, rsp_tag, rsp_rdata});
            end
        end
    end

    always @(negedge clk) begin
        assert (!(req_valid && req_rmask != 4'h0 && req_wmask != 4'h0))
            else $error("both masks set on a request");
        assert (!(rst && dmem_resp && dut.state_q == IDLE))
            else $error("dmem_resp driven while idle");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                           input logic [31:0] wd, input logic [TAG_W-1:0] t);
        req_valid = 1'b1;
        req_addr  = a;
        req_rmask = rm;
        req_wmask = wm;
        req_wdata = wd;
        req_tag   = t;
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input logic [TAG_W-1:0] t);
        set_req(a, rm, wm, wd, t);
        cyc();
        req_valid = 1'b0;
    endtask

    // Called at posedge+1 of a WAIT cycle; returns at posedge+1 of the following cycle.
    task automatic respond(input logic [31:0] rd);
        dmem_resp  = 1'b1;
        dmem_rdata = rd;
        @(negedge clk);
        got_valid = rsp_valid;
        got_tag   = rsp_tag;
        got_rdata = rsp_rdata;
        got_load  = rsp_is_load;
        got_ready = req_ready;
        cyc();
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_dmem_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // Single load
        push(32'h100, 4'hF, 4'h0, 32'h0, 4'd3);
        @(negedge clk);
        check("load_rmask_pulse", 32'(dmem_rmask), 32'hF);
        check("load_wmask_zero", 32'(dmem_wmask), 32'h0);
        check("load_addr", dmem_addr, 32'h100);
        cyc();
        @(negedge clk);
        check("load_rmask_drop", 32'(dmem_rmask), 32'h0);
        check("load_addr_held", dmem_addr, 32'h100);
        cyc();
        cyc();
        cyc();
        respond(32'hDEAD_BEEF);
        check("load_rsp_valid", 32'(got_valid), 32'd1);
        check("load_rsp_tag", 32'(got_tag), 32'd3);
        check("load_rsp_rdata", got_rdata, 32'hDEAD_BEEF);
        check("load_rsp_is_load", 32'(got_load), 32'd1);
        @(negedge clk);
        check("load_rsp_drop", 32'(rsp_valid), 32'd0);
        check("load_count_empty", 32'(dut.count), 32'd0);
        check("load_one_issue", 32'(issues.size()), 32'd1);
        cyc();

        // Fill with responses withheld
        issues.delete();
        rsps.delete();
        for (int t = 0; t < 4; t++) begin
            push(32'h200 + 32'(4 * t), 4'hF, 4'h0, 32'h0, TAG_W'(t));
        end
        @(negedge clk);
        check("fill_ready_low", 32'(req_ready), 32'd0);
        check("fill_count", 32'(dut.count), 32'd4);
        check("fill_issued_one", 32'(issues.size()), 32'd1);
        cyc();
        for (int k = 0; k < 4; k++) begin
            respond(32'h1000 + 32'(k));
            check("fill_rsp_valid", 32'(got_valid), 32'd1);
            check("fill_rsp_tag", 32'(got_tag), 32'(k));
            if (k == 0) begin
                check("fill_ready_on_pop", 32'(got_ready), 32'd0);
            end
            cyc();
        end
        check("fill_issue_count", 32'(issues.size()), 32'd4);
        for (int k = 0; k < 4 && k < issues.size(); k++) begin
            check("fill_issue_addr", issues[k][39:8], 32'h200 + 32'(4 * k));
        end

        // Store
        push(32'h204, 4'h0, 4'h3, 32'h1234, 4'd5);
        @(negedge clk);
        check("store_wmask_pulse", 32'(dmem_wmask), 32'h3);
        check("store_rmask_zero", 32'(dmem_rmask), 32'h0);
        check("store_wdata", dmem_wdata, 32'h1234);
        check("store_addr", dmem_addr, 32'h204);
        cyc();
        respond(32'hFFFF_FFFF);
        check("store_rsp_valid", 32'(got_valid), 32'd1);
        check("store_rsp_tag", 32'(got_tag), 32'd5);
        check("store_rsp_rdata", got_rdata, 32'h0);
        check("store_rsp_is_load", 32'(got_load), 32'd0);
        cyc();

        // Flush while waiting with 3 queued
        issues.delete();
        rsps.delete();
        push(32'h300, 4'hF, 4'h0, 32'h0, 4'd8);
        push(32'h304, 4'hF, 4'h0, 32'h0, 4'd9);
        push(32'h308, 4'hF, 4'h0, 32'h0, 4'd10);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        check("flush_keeps_head", 32'(dut.count), 32'd1);
        cyc();
        respond(32'h55);
        check("flush_rsp_suppressed", 32'(got_valid), 32'd0);
        for (int i = 0; i < 5; i++) cyc();
        check("flush_count_empty", 32'(dut.count), 32'd0);
        check("flush_no_reissue", 32'(issues.size()), 32'd1);
        check("flush_no_rsp", 32'(rsps.size()), 32'd0);

        // Push and pop in the same cycle at count 2, then a zero-mask push
        issues.delete();
        rsps.delete();
        push(32'h400, 4'hF, 4'h0, 32'h0, 4'd1);
        push(32'h404, 4'hF, 4'h0, 32'h0, 4'd2);
        set_req(32'h408, 4'hF, 4'h0, 32'h0, 4'd3);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hA;
        @(negedge clk);
        got_valid = rsp_valid;
        cyc();
        req_valid = 1'b0;
        dmem_resp = 1'b0;
        @(negedge clk);
        check("pp_count_held", 32'(dut.count), 32'd2);
        check("pp_rsp_valid", 32'(got_valid), 32'd1);
        cyc();
        set_req(32'h40C, 4'h0, 4'h0, 32'h0, 4'hE);
        cyc();
        req_valid = 1'b0;
        @(negedge clk);
        check("zero_mask_count", 32'(dut.count), 32'd2);
        cyc();
        respond(32'hB);
        cyc();
        respond(32'hC);
        for (int i = 0; i < 4; i++) cyc();
        check("pp_issue_count", 32'(issues.size()), 32'd3);
        check("pp_rsp_count", 32'(rsps.size()), 32'd3);
        for (int k = 0; k < 3 && k < issues.size(); k++) begin
            check("pp_issue_addr", issues[k][39:8], 32'h400 + 32'(4 * k));
        end
        for (int k = 0; k < 3 && k < rsps.size(); k++) begin
            check("pp_rsp_tag", 32'(rsps[k][35:32]), 32'(k + 1));
        end

        // Reset asserted mid-WAIT
        issues.delete();
        rsps.delete();
        push(32'h500, 4'hF, 4'h0, 32'h0, 4'd7);
        @(negedge clk);
        cyc();
        rst       = 1'b0;
        dmem_resp = 1'b1;
        #1;
        check("rstw_dmem_addr", dmem_addr, 32'h0);
        check("rstw_dmem_masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
        check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw_req_ready", 32'(req_ready), 32'd1);
        cyc();
        dmem_resp = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("rstw_count_empty", 32'(dut.count), 32'd0);
        check("rstw_no_reissue", 32'(issues.size()), 32'd1);
        check("rstw_no_rsp", 32'(rsps.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
